// File: rtl/rfphoenix_vec_wb.sv
// Vector register-file writeback queue: two-producer round-robin arbiter feeding
// a small FIFO that drains one entry per clock, plus a pending-write RAW lookup.
module rfphoenix_vec_wb #(
  parameter int NLANES = 16,
  parameter int LANEW  = 32,
  parameter int TIDW   = 4,
  parameter int REGW   = 6,
  parameter int DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        p0_valid,
  output logic                        p0_ready,
  input  logic [TIDW-1:0]             p0_thread,
  input  logic [REGW-1:0]             p0_reg,
  input  logic [NLANES-1:0]           p0_mask,
  input  logic [NLANES*LANEW-1:0]     p0_data,
  input  logic                        p1_valid,
  output logic                        p1_ready,
  input  logic [TIDW-1:0]             p1_thread,
  input  logic [REGW-1:0]             p1_reg,
  input  logic [NLANES-1:0]           p1_mask,
  input  logic [NLANES*LANEW-1:0]     p1_data,
  input  logic                        wb_hold,
  output logic                        wr,
  output logic [TIDW-1:0]             wthread,
  output logic [REGW-1:0]             wa,
  output logic [NLANES-1:0]           wmask,
  output logic [NLANES*LANEW-1:0]     i,
  input  logic [TIDW-1:0]             chk_thread,
  input  logic [REGW-1:0]             chk_reg,
  output logic                        chk_pending,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = NLANES * LANEW;

  typedef enum logic {RR_P0 = 1'b0, RR_P1 = 1'b1} rr_t;

  rr_t                rr;
  logic [TIDW-1:0]    q_thread [DEPTH];
  logic [REGW-1:0]    q_reg    [DEPTH];
  logic [NLANES-1:0]  q_mask   [DEPTH];
  logic [DW-1:0]      q_data   [DEPTH];
  logic [AW-1:0]      rd_ptr, wr_ptr, idx;
  logic [CW-1:0]      occ;
  logic               full, acc0, acc1, push, pop, both_valid;
  logic [TIDW-1:0]    in_thread;
  logic [REGW-1:0]    in_reg;
  logic [NLANES-1:0]  in_mask;
  logic [DW-1:0]      in_data;

  assign count      = occ;
  assign full       = (occ == CW'(DEPTH));
  assign both_valid = p0_valid & p1_valid;

  // No same-cycle credit: a pop in this cycle does not open a slot for a grant.
  always_comb begin
    p0_ready = 1'b0;
    p1_ready = 1'b0;
    if (!full) begin
      if (p0_valid && (!p1_valid || rr == RR_P0)) p0_ready = 1'b1;
      if (p1_valid && (!p0_valid || rr == RR_P1)) p1_ready = 1'b1;
    end
  end

  assign acc0 = p0_valid & p0_ready;
  assign acc1 = p1_valid & p1_ready;

  always_comb begin
    in_thread = p0_thread;
    in_reg    = p0_reg;
    in_mask   = p0_mask;
    in_data   = p0_data;
    if (acc1) begin
      in_thread = p1_thread;
      in_reg    = p1_reg;
      in_mask   = p1_mask;
      in_data   = p1_data;
    end
  end

  // Zero-mask results complete the handshake but never occupy a slot.
  assign push = (acc0 | acc1) & (in_mask != '0);
  assign pop  = (occ != '0) & ~wb_hold;

  always_ff @(posedge clk) begin
    if (push) begin
      q_thread[wr_ptr] <= in_thread;
      q_reg[wr_ptr]    <= in_reg;
      q_mask[wr_ptr]   <= in_mask;
      q_data[wr_ptr]   <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      occ     <= '0;
      rr      <= RR_P0;
      wr      <= 1'b0;
      wthread <= '0;
      wa      <= '0;
      wmask   <= '0;
      i       <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (both_valid && !full) rr <= (rr == RR_P0) ? RR_P1 : RR_P0;
      wr <= pop;
      if (pop) begin
        wthread <= q_thread[rd_ptr];
        wa      <= q_reg[rd_ptr];
        wmask   <= q_mask[rd_ptr];
        i       <= q_data[rd_ptr];
      end
    end
  end

  // Walk slots relative to the head so only occupied entries can match.
  always_comb begin
    chk_pending = 1'b0;
    idx         = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + AW'(k);
      if (CW'(k) < occ && q_thread[idx] == chk_thread && q_reg[idx] == chk_reg)
        chk_pending = 1'b1;
    end
    if (wr && wthread == chk_thread && wa == chk_reg) chk_pending = 1'b1;
  end

endmodule

// File: tb/tb_rfphoenix_vec_wb.sv
// Bench for rfphoenix_vec_wb: directed vector table, hand sequences for hazard and
// reset corners, then random traffic against a queue-based reference model.
module tb_rfphoenix_vec_wb;

  localparam int DEPTH = 4;

  logic         clk, rst;
  logic         p0_valid, p0_ready, p1_valid, p1_ready;
  logic [3:0]   p0_thread, p1_thread, wthread, chk_thread;
  logic [5:0]   p0_reg, p1_reg, wa, chk_reg;
  logic [15:0]  p0_mask, p1_mask, wmask;
  logic [511:0] p0_data, p1_data, i;
  logic         wb_hold, wr, chk_pending;
  logic [2:0]   count;

  rfphoenix_vec_wb #(.NLANES(16), .LANEW(32), .TIDW(4), .REGW(6), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_thread(p0_thread), .p0_reg(p0_reg),
    .p0_mask(p0_mask), .p0_data(p0_data),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_thread(p1_thread), .p1_reg(p1_reg),
    .p1_mask(p1_mask), .p1_data(p1_data),
    .wb_hold(wb_hold), .wr(wr), .wthread(wthread), .wa(wa), .wmask(wmask), .i(i),
    .chk_thread(chk_thread), .chk_reg(chk_reg), .chk_pending(chk_pending), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] lanes(input int b);
    logic [511:0] r;
    for (int j = 0; j < 16; j++) r[j*32 +: 32] = {16'h0, 8'(b), 8'(j)};
    return r;
  endfunction

  // Reference model: a plain queue of pending writes plus the last write-port values.
  typedef struct {
    logic [3:0]   t;
    logic [5:0]   r;
    logic [15:0]  m;
    logic [511:0] d;
  } ent_t;

  ent_t         mq[$];
  logic         m_wr, m_rr, m_full, m_r0, m_r1;
  logic [3:0]   m_t;
  logic [5:0]   m_a;
  logic [15:0]  m_m;
  logic [511:0] m_d;

  task automatic model_reset();
    mq.delete();
    m_wr = 0; m_rr = 0; m_t = '0; m_a = '0; m_m = '0; m_d = '0;
  endtask

  task automatic model_check();
    logic pend;
    m_full = (mq.size() == DEPTH);
    m_r0 = !m_full && p0_valid && (!p1_valid || m_rr == 1'b0);
    m_r1 = !m_full && p1_valid && (!p0_valid || m_rr == 1'b1);
    pend = m_wr && m_t == chk_thread && m_a == chk_reg;
    foreach (mq[k]) if (mq[k].t == chk_thread && mq[k].r == chk_reg) pend = 1'b1;
    check("m_p0_ready", 512'(p0_ready), 512'(m_r0));
    check("m_p1_ready", 512'(p1_ready), 512'(m_r1));
    check("m_count", 512'(count), 512'(mq.size()));
    check("m_wr", 512'(wr), 512'(m_wr));
    check("m_chk_pending", 512'(chk_pending), 512'(pend));
    if (m_wr) begin
      check("m_wthread", 512'(wthread), 512'(m_t));
      check("m_wa", 512'(wa), 512'(m_a));
      check("m_wmask", 512'(wmask), 512'(m_m));
      check("m_data", i, m_d);
    end
  endtask

  task automatic model_update();
    ent_t e;
    if (mq.size() > 0 && !wb_hold) begin
      e = mq.pop_front();
      m_wr = 1; m_t = e.t; m_a = e.r; m_m = e.m; m_d = e.d;
    end else m_wr = 0;
    if (m_r0 && p0_mask != 0) mq.push_back('{p0_thread, p0_reg, p0_mask, p0_data});
    else if (m_r1 && p1_mask != 0) mq.push_back('{p1_thread, p1_reg, p1_mask, p1_data});
    if (p0_valid && p1_valid && !m_full) m_rr = ~m_rr;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic tick();
    #1 model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic drive(input int v0, g0, m0, b0, v1, g1, m1, b1, t, hold, ct, cr);
    p0_valid = 1'(v0); p0_reg = 6'(g0); p0_mask = 16'(m0); p0_data = lanes(b0);
    p1_valid = 1'(v1); p1_reg = 6'(g1); p1_mask = 16'(m1); p1_data = lanes(b1);
    p0_thread = 4'(t); p1_thread = 4'(t); wb_hold = 1'(hold);
    chk_thread = 4'(ct); chk_reg = 6'(cr);
  endtask

  typedef struct {
    int v0, g0, m0, b0, v1, g1, m1, b1, t, hold, ct, cr;
    int er0, er1, ewr, ewt, ewa, ewm, eb, ecnt, epend;
  } vec_t;

  function automatic vec_t row(input int v0, g0, m0, b0, v1, g1, m1, b1, t, hold, ct, cr,
                               er0, er1, ewr, ewt, ewa, ewm, eb, ecnt, epend);
    return '{v0, g0, m0, b0, v1, g1, m1, b1, t, hold, ct, cr,
             er0, er1, ewr, ewt, ewa, ewm, eb, ecnt, epend};
  endfunction

  vec_t tbl[29];

  initial begin
    // Field order: v0,g0,m0,b0, v1,g1,m1,b1, t,hold, ct,cr, er0,er1, ewr,ewt,ewa,ewm,eb, ecnt,epend
    // Single write: thread 3 reg 5, lane data = lane index.
    tbl[0]  = row(1,5,'hFFFF,0,  0,0,0,0,  3,0, 15,63, 1,0, 0,0,0,0,0,        0,0);
    tbl[1]  = row(0,0,0,0,       0,0,0,0,  0,0, 15,63, 0,0, 0,0,0,0,0,        1,0);
    tbl[2]  = row(0,0,0,0,       0,0,0,0,  0,0, 15,63, 0,0, 1,3,5,'hFFFF,0,   0,0);
    tbl[3]  = row(0,0,0,0,       0,0,0,0,  0,0, 15,63, 0,0, 0,0,0,0,0,        0,0);
    // Contention: grants alternate p0,p1,p0,p1.
    tbl[4]  = row(1,10,'hFFFF,10, 1,11,'hFFFF,11, 1,0, 15,63, 1,0, 0,0,0,0,0,          0,0);
    tbl[5]  = row(1,12,'hFFFF,12, 1,11,'hFFFF,11, 1,0, 15,63, 0,1, 0,0,0,0,0,          1,0);
    tbl[6]  = row(1,12,'hFFFF,12, 1,13,'hFFFF,13, 1,0, 15,63, 1,0, 1,1,10,'hFFFF,10,   1,0);
    tbl[7]  = row(1,14,'hFFFF,14, 1,13,'hFFFF,13, 1,0, 15,63, 0,1, 1,1,11,'hFFFF,11,   1,0);
    tbl[8]  = row(0,0,0,0,       0,0,0,0,  0,0, 15,63, 0,0, 1,1,12,'hFFFF,12, 1,0);
    tbl[9]  = row(0,0,0,0,       0,0,0,0,  0,0, 15,63, 0,0, 1,1,13,'hFFFF,13, 0,0);
    tbl[10] = row(0,0,0,0,       0,0,0,0,  0,0, 15,63, 0,0, 0,0,0,0,0,        0,0);
    // Full / hold: five pushes, fifth refused on both ports, then four drains.
    tbl[11] = row(1,20,'h0F0F,20, 0,0,0,0, 1,1, 15,63, 1,0, 0,0,0,0,0, 0,0);
    tbl[12] = row(1,21,'h0F0F,21, 0,0,0,0, 1,1, 15,63, 1,0, 0,0,0,0,0, 1,0);
    tbl[13] = row(1,22,'h0F0F,22, 0,0,0,0, 1,1, 15,63, 1,0, 0,0,0,0,0, 2,0);
    tbl[14] = row(1,23,'h0F0F,23, 0,0,0,0, 1,1, 15,63, 1,0, 0,0,0,0,0, 3,0);
    tbl[15] = row(1,24,'h0F0F,24, 1,25,'h0F0F,25, 1,1, 15,63, 0,0, 0,0,0,0,0, 4,0);
    tbl[16] = row(0,0,0,0,       0,0,0,0,  0,0, 15,63, 0,0, 0,0,0,0,0,        4,0);
    tbl[17] = row(0,0,0,0,       0,0,0,0,  0,0, 15,63, 0,0, 1,1,20,'h0F0F,20, 3,0);
    tbl[18] = row(0,0,0,0,       0,0,0,0,  0,0, 15,63, 0,0, 1,1,21,'h0F0F,21, 2,0);
    tbl[19] = row(0,0,0,0,       0,0,0,0,  0,0, 15,63, 0,0, 1,1,22,'h0F0F,22, 1,0);
    tbl[20] = row(0,0,0,0,       0,0,0,0,  0,0, 15,63, 0,0, 1,1,23,'h0F0F,23, 0,0);
    tbl[21] = row(0,0,0,0,       0,0,0,0,  0,0, 15,63, 0,0, 0,0,0,0,0,        0,0);
    // Zero mask: accepted, never enqueued or written.
    tbl[22] = row(0,0,0,0,       1,30,0,30, 0,0, 15,63, 0,1, 0,0,0,0,0, 0,0);
    tbl[23] = row(0,0,0,0,       0,0,0,0,  0,0, 15,63, 0,0, 0,0,0,0,0, 0,0);
    tbl[24] = row(0,0,0,0,       0,0,0,0,  0,0, 15,63, 0,0, 0,0,0,0,0, 0,0);
    // Hazard {2,7}: pending from enqueue until the cycle after its write pulse.
    tbl[25] = row(1,7,'hF0F0,7,  0,0,0,0,  2,0, 2,7, 1,0, 0,0,0,0,0,        0,0);
    tbl[26] = row(0,0,0,0,       0,0,0,0,  0,0, 2,7, 0,0, 0,0,0,0,0,        1,1);
    tbl[27] = row(0,0,0,0,       0,0,0,0,  0,0, 2,7, 0,0, 1,2,7,'hF0F0,7,   0,1);
    tbl[28] = row(0,0,0,0,       0,0,0,0,  0,0, 2,7, 0,0, 0,0,0,0,0,        0,0);

    rst = 1'b0;
    drive(0,0,0,0, 0,0,0,0, 0,0, 2,7);
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("reset_wr", 512'(wr), 512'(0));
    check("reset_count", 512'(count), 512'(0));
    check("reset_chk_pending", 512'(chk_pending), 512'(0));
    check("reset_wthread_wa", 512'({wthread, wa}), 512'(0));
    check("reset_data", i, 512'(0));
    @(negedge clk);
    rst = 1'b1;

    foreach (tbl[n]) begin
      drive(tbl[n].v0, tbl[n].g0, tbl[n].m0, tbl[n].b0, tbl[n].v1, tbl[n].g1, tbl[n].m1,
            tbl[n].b1, tbl[n].t, tbl[n].hold, tbl[n].ct, tbl[n].cr);
      #1;
      check($sformatf("t%0d_p0_ready", n), 512'(p0_ready), 512'(tbl[n].er0));
      check($sformatf("t%0d_p1_ready", n), 512'(p1_ready), 512'(tbl[n].er1));
      check($sformatf("t%0d_wr", n), 512'(wr), 512'(tbl[n].ewr));
      check($sformatf("t%0d_count", n), 512'(count), 512'(tbl[n].ecnt));
      check($sformatf("t%0d_chk_pending", n), 512'(chk_pending), 512'(tbl[n].epend));
      if (tbl[n].ewr != 0) begin
        check($sformatf("t%0d_wthread", n), 512'(wthread), 512'(tbl[n].ewt));
        check($sformatf("t%0d_wa", n), 512'(wa), 512'(tbl[n].ewa));
        check($sformatf("t%0d_wmask", n), 512'(wmask), 512'(tbl[n].ewm));
        check($sformatf("t%0d_data", n), i, lanes(tbl[n].eb));
      end
      tick();
    end

    // Held hazard: neighbouring register of the same thread must not match.
    drive(1,7,'hFFFF,70, 0,0,0,0, 2,1, 2,8);
    tick();
    drive(0,0,0,0, 0,0,0,0, 0,1, 2,8);
    #1 check("hz_other_reg", 512'(chk_pending), 512'(0));
    chk_reg = 6'd7;
    #1 check("hz_same_reg", 512'(chk_pending), 512'(1));
    tick();
    drive(0,0,0,0, 0,0,0,0, 0,0, 2,8);
    repeat (3) tick();

    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 3),
            ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 'hFFFF), $urandom_range(0, 255),
            $urandom_range(0, 1), $urandom_range(0, 3),
            ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 'hFFFF), $urandom_range(0, 255),
            $urandom_range(0, 3), ($urandom_range(0, 9) < 3) ? 1 : 0,
            $urandom_range(0, 3), $urandom_range(0, 3));
      tick();
    end

    // Reset mid-operation with a write in flight and entries still queued.
    drive(0,0,0,0, 0,0,0,0, 0,0, 15,63);
    repeat (6) tick();
    for (int n = 0; n < 3; n++) begin
      drive(1, 40 + n, 'hFFFF, 40 + n, 0,0,0,0, 5,1, 15,63);
      tick();
    end
    drive(0,0,0,0, 0,0,0,0, 5,0, 5,42);
    tick();
    #2 rst = 1'b0;
    #1;
    check("rst_async_wr", 512'(wr), 512'(0));
    check("rst_async_count", 512'(count), 512'(0));
    check("rst_async_chk_pending", 512'(chk_pending), 512'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 6; n++) begin
      #1 check($sformatf("rst_drained_wr%0d", n), 512'(wr), 512'(0));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rfphoenix_vec_wb.md
Name: rfphoenix_vec_wb

Overview:
Writeback arbiter and queue on the write side of the vector register file. It accepts completed vector results from two producers, the ALU (port 0) and the load/store unit (port 1), over valid/ready handshakes, and buffers them in a small FIFO. It drains one entry per clock onto the register-file write port (wr, wthread, wmask, wa, i). It also provides a pending-write lookup that issue logic uses for RAW hazard checks.

Parameters:
NLANES, 16, number of 32-bit lanes per vector.
LANEW, 32, bits per lane.
TIDW, 4, thread-id width.
REGW, 6, register-specifier width (TIDW+REGW = 10 = regfile address width).
DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  reset, asynchronous, active-low.
p0_valid  in  1  ALU result valid.
p0_ready  out  1  ALU result accepted this cycle.
p0_thread  in  TIDW  ALU destination thread.
p0_reg  in  REGW  ALU destination register.
p0_mask  in  NLANES  ALU lane write mask.
p0_data  in  NLANES*LANEW  ALU result vector.
p1_valid, p1_ready, p1_thread, p1_reg, p1_mask, p1_data  same as p0_*, for the LSU.
wb_hold  in  1  freeze drain; no pop while high.
wr  out  1  register-file write strobe.
wthread  out  TIDW  write thread.
wa  out  REGW  write register.
wmask  out  NLANES  write lane mask.
i  out  NLANES*LANEW  write data.
chk_thread  in  TIDW  hazard-query thread.
chk_reg  in  REGW  hazard-query register.
chk_pending  out  1  query matches a queued or in-flight write.
count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst low, asynchronous): FIFO emptied (rd/wr pointers = 0, count = 0); wr, wthread, wa, wmask, i = 0; round-robin pointer = port 0. Entries mid-queue are discarded. First accept is possible on the first edge after rst deasserts.
- Arbitration is combinational:
  - full = (count == DEPTH).
  - If full: p0_ready = p1_ready = 0.
  - Else if exactly one port is valid, that port's ready = 1.
  - If both are valid, only the port named by the rr pointer gets ready = 1. The rr pointer toggles after each edge where both were valid and one was accepted.
  - Ready is never granted when full, even if a pop occurs the same cycle (no same-cycle credit).
- Accept: valid & ready at an edge. If mask != 0, {thread, reg, mask, data} is written at the FIFO tail. If mask == 0, the handshake completes but nothing is enqueued.
- Drain:
  - At each edge where count > 0 and wb_hold = 0, the head entry is popped into the output registers and wr = 1 for the following cycle.
  - Otherwise wr = 0 next cycle, and wthread/wa/wmask/i hold their last values.
  - wr is asserted for exactly one cycle per entry. There is no backpressure from the register file.
- Latency: an entry accepted at edge E into an empty FIFO with wb_hold low drives wr high in the cycle after edge E+1. Order is strictly FIFO.
- Simultaneous push and pop: count unchanged. Push alone: +1. Pop alone: -1. Pointers wrap modulo DEPTH.
- chk_pending is combinational. It is 1 if any occupied FIFO entry matches {chk_thread, chk_reg}, or if wr = 1 and {wthread, wa} matches. It is 0 otherwise and during reset.
- count reflects the registered occupancy and never exceeds DEPTH.

Test Plan:
- Single write: p0 valid, thread 3, reg 5, mask FFFF, data lanes = lane index. Required response: p0_ready = 1; wr high exactly one cycle, two edges later; wthread = 3, wa = 5, wmask = FFFF, i matches.
- Contention: p0 and p1 both valid for 4 cycles with distinct regs. Required response: grants alternate p0, p1, p0, p1; writes emerge in that order.
- Full / hold: wb_hold = 1 and 5 pushes. Required response: count reaches 4, both readies = 0 on the 5th. Release hold: 4 consecutive wr pulses; count returns to 0.
- Zero mask: p1 valid with mask 0000. Required response: p1_ready = 1, count stays 0, no wr pulse.
- Hazard: queue thread 2 reg 7, then query chk = {2,7}. Required response: chk_pending = 1 until the cycle after its wr pulse; query {2,8} returns 0.
- Reset mid-operation: 3 entries queued, rst pulsed low asynchronously. Required response: wr = 0 immediately, count = 0, chk_pending = 0, and the queued entries are never written.
